rf_hazard_ctrl: RTL and testbench

//   Register-fetch stage controller for the pipelined LEGv8 core. Decodes the RF-stage instruction
//   to drive the immediate-select and use-immediate controls. Detects load-use hazards against
//   the EX stage and sequences a one-cycle stall plus ID/EX bubble. Counts stall cycles for

---
 rtl/rf_hazard_ctrl.sv | 92 +++++++++
 tb/tb_rf_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_hazard_ctrl.sv
// RF-stage controller: immediate-select decode, load-use hazard detection with a
// one-cycle stall/bubble sequencer, and a saturating stall-cycle counter.
module rf_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr,
   input  logic             instr_valid,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             flush,
   output logic             imm_sel,
   output logic             use_imm,
   output logic             stall,
   output logic             bubble,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic {RUN, STALL} state_t;

   typedef struct packed {
      logic ldst;   // LDUR or STUR
      logic stur;
      logic alui;   // ADDI or SUBI
      logic rtype;
      logic cbz;
   } dec_t;

   state_t           state;
   dec_t             dec;
   logic             haz;
   logic             hit_rn, hit_rm, hit_rt;
   logic [CNT_W-1:0] cnt;

   assign stall_cnt = cnt;

   always_comb begin
      dec       = '0;
      dec.stur  = instr_valid && (instr[31:21] == 11'b11111000000);
      dec.ldst  = dec.stur || (instr_valid && (instr[31:21] == 11'b11111000010));
      dec.alui  = instr_valid && ((instr[31:22] == 10'b1001000100) ||
                                  (instr[31:22] == 10'b1101000100));
      // Register-operand data-processing class (ADD/SUB/AND/ORR): bits 28:25 = 0101
      dec.rtype = instr_valid && !dec.ldst && !dec.alui && (instr[28:25] == 4'b0101);
      dec.cbz   = instr_valid && (instr[31:24] == 8'b10110100);
   end

   // ex_rd != 31 already excludes XZR sources from matching
   always_comb begin
      hit_rn = (dec.rtype || dec.alui || dec.ldst) && (instr[9:5]   == ex_rd);
      hit_rm = dec.rtype                           && (instr[20:16] == ex_rd);
      hit_rt = (dec.stur || dec.cbz)               && (instr[4:0]   == ex_rd);
      haz    = instr_valid && ex_mem_read && (ex_rd != 5'd31) && (hit_rn || hit_rm || hit_rt);
   end

   always_comb begin
      imm_sel = 1'b0;
      use_imm = 1'b0;
      stall   = 1'b0;
      bubble  = 1'b1;
      if (!reset) begin
         imm_sel = dec.ldst;
         use_imm = dec.ldst || dec.alui;
         if (state == RUN) begin
            stall  = haz && !flush;
            bubble = haz || flush;
         end else begin
            bubble = flush;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         case (state)
            RUN: begin
               if (haz && !flush) begin
                  state <= STALL;
                  if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
               end
            end
            // The load has left EX by now, so leave unconditionally
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_rf_hazard_ctrl.sv
// Self-checking bench for rf_hazard_ctrl: directed scenarios plus randomized traffic
// against a cycle-level reference model; a second instance exercises counter saturation.
module tb_rf_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        instr_valid, ex_mem_read, flush;
   logic [4:0]  ex_rd;
   logic        imm_sel, use_imm, stall, bubble;
   logic [15:0] stall_cnt;
   logic        imm_sel2, use_imm2, stall2, bubble2;
   logic [1:0]  stall_cnt2;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [10:0] OP_LDUR = 11'h7C2, OP_STUR = 11'h7C0;
   localparam logic [10:0] OP_ADD = 11'h458, OP_SUB = 11'h658, OP_AND = 11'h450, OP_ORR = 11'h550;
   localparam logic [9:0]  OP_ADDI = 10'h244, OP_SUBI = 10'h344;
   localparam logic [7:0]  OP_CBZ = 8'hB4;

   always #5 clk = ~clk;

   rf_hazard_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .flush(flush),
      .imm_sel(imm_sel), .use_imm(use_imm), .stall(stall), .bubble(bubble),
      .stall_cnt(stall_cnt));

   rf_hazard_ctrl #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .flush(flush),
      .imm_sel(imm_sel2), .use_imm(use_imm2), .stall(stall2), .bubble(bubble2),
      .stall_cnt(stall_cnt2));

   function automatic logic [31:0] enc_r(logic [10:0] op, int rd, int rn, int rm);
      return {op, rm[4:0], 6'd0, rn[4:0], rd[4:0]};
   endfunction
   function automatic logic [31:0] enc_i(logic [9:0] op, int rd, int rn, int imm);
      return {op, imm[11:0], rn[4:0], rd[4:0]};
   endfunction
   function automatic logic [31:0] enc_d(logic [10:0] op, int rt, int rn, int imm);
      return {op, imm[8:0], 2'b00, rn[4:0], rt[4:0]};
   endfunction
   function automatic logic [31:0] enc_cb(int rt, int imm);
      return {OP_CBZ, imm[18:0], rt[4:0]};
   endfunction

   task automatic drive(logic [31:0] i, logic v, logic mr, logic [4:0] rd, logic fl);
      instr = i; instr_valid = v; ex_mem_read = mr; ex_rd = rd; flush = fl;
      #2;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      tick();
      reset = 1'b0;
      #1;
   endtask

   // Reference: which registers an instruction reads, as a 32-bit mask
   function automatic logic [31:0] src_mask(logic [31:0] i);
      logic [31:0] m;
      logic ls, st, ai, rt, cb;
      m  = '0;
      st = (i[31:21] == OP_STUR);
      ls = st || (i[31:21] == OP_LDUR);
      ai = (i[31:22] == OP_ADDI) || (i[31:22] == OP_SUBI);
      rt = !ls && !ai && (i[28:25] == 4'b0101);
      cb = (i[31:24] == OP_CBZ);
      if (ls || ai || rt) m[i[9:5]] = 1'b1;
      if (rt)             m[i[20:16]] = 1'b1;
      if (st || cb)       m[i[4:0]] = 1'b1;
      m[31] = 1'b0;
      return m;
   endfunction

   task automatic test_reset();
      do_reset();
      drive(enc_r(OP_ADD, 4, 3, 5), 1'b1, 1'b1, 5'd3, 1'b0);
      n_checks++;
      if (stall !== 1'b1) begin n_errors++; $display("FAIL reset_pre_stall got=%b exp=1", stall); end
      tick();
      n_checks++;
      if ({stall, bubble} !== 2'b00) begin n_errors++; $display("FAIL reset_in_stall got=%b exp=00", {stall, bubble}); end
      drive(enc_d(OP_STUR, 3, 6, 8), 1'b1, 1'b1, 5'd3, 1'b0);
      reset = 1'b1;
      #1;
      n_checks++;
      if ({imm_sel, use_imm, stall, bubble, stall_cnt} !== {4'b0001, 16'd0}) begin
         n_errors++; $display("FAIL reset_async got=%b cnt=%0d exp=0001 cnt=0", {imm_sel, use_imm, stall, bubble}, stall_cnt);
      end
      tick();
      reset = 1'b0;
      #1;
      n_checks++;
      if ({imm_sel, use_imm, stall, bubble} !== 4'b1111) begin
         n_errors++; $display("FAIL reset_release_run got=%b exp=1111", {imm_sel, use_imm, stall, bubble});
      end
   endtask

   task automatic test_decode();
      do_reset();
      drive(enc_i(OP_ADDI, 1, 2, 5), 1'b1, 1'b0, 5'd2, 1'b0);
      n_checks++;
      if ({imm_sel, use_imm, stall, bubble} !== 4'b0100) begin
         n_errors++; $display("FAIL addi_decode got=%b exp=0100", {imm_sel, use_imm, stall, bubble});
      end
      drive(enc_i(OP_SUBI, 1, 2, 5), 1'b1, 1'b1, 5'd2, 1'b0);
      n_checks++;
      if ({imm_sel, use_imm, stall, bubble} !== 4'b0111) begin
         n_errors++; $display("FAIL subi_haz got=%b exp=0111", {imm_sel, use_imm, stall, bubble});
      end
      drive(enc_d(OP_LDUR, 3, 2, 1), 1'b0, 1'b1, 5'd2, 1'b0);
      n_checks++;
      if ({imm_sel, use_imm, stall, bubble} !== 4'b0000) begin
         n_errors++; $display("FAIL invalid_gate got=%b exp=0000", {imm_sel, use_imm, stall, bubble});
      end
      drive(enc_cb(9, 4), 1'b1, 1'b1, 5'd9, 1'b0);
      n_checks++;
      if ({imm_sel, use_imm, stall} !== 3'b001) begin
         n_errors++; $display("FAIL cbz_rt got=%b exp=001", {imm_sel, use_imm, stall});
      end
      do_reset();
   endtask

   task automatic test_load_use();
      do_reset();
      drive(enc_r(OP_ADD, 4, 3, 5), 1'b1, 1'b1, 5'd3, 1'b0);
      n_checks++;
      if ({stall, bubble} !== 2'b11) begin n_errors++; $display("FAIL lu_stall got=%b exp=11", {stall, bubble}); end
      tick();
      n_checks++;
      if ({stall, bubble, stall_cnt} !== {2'b00, 16'd1}) begin
         n_errors++; $display("FAIL lu_release got=%b cnt=%0d exp=00 cnt=1", {stall, bubble}, stall_cnt);
      end
      drive(enc_r(OP_ORR, 7, 1, 8), 1'b1, 1'b1, 5'd8, 1'b0);
      n_checks++;
      if (stall !== 1'b0) begin n_errors++; $display("FAIL lu_stall_state got=%b exp=0", stall); end
      tick();
      n_checks++;
      if ({stall, bubble, stall_cnt} !== {2'b11, 16'd1}) begin
         n_errors++; $display("FAIL back_to_back got=%b cnt=%0d exp=11 cnt=1", {stall, bubble}, stall_cnt);
      end
      tick();
      n_checks++;
      if (stall_cnt !== 16'd2) begin n_errors++; $display("FAIL back_to_back_cnt got=%0d exp=2", stall_cnt); end
   endtask

   task automatic test_stur();
      do_reset();
      drive(enc_d(OP_STUR, 3, 6, 8), 1'b1, 1'b1, 5'd3, 1'b0);
      n_checks++;
      if ({imm_sel, use_imm, stall, bubble} !== 4'b1111) begin
         n_errors++; $display("FAIL stur_rt got=%b exp=1111", {imm_sel, use_imm, stall, bubble});
      end
      do_reset();
      drive(enc_d(OP_STUR, 31, 31, 8), 1'b1, 1'b1, 5'd31, 1'b0);
      n_checks++;
      if ({imm_sel, use_imm, stall, bubble} !== 4'b1100) begin
         n_errors++; $display("FAIL stur_xzr got=%b exp=1100", {imm_sel, use_imm, stall, bubble});
      end
   endtask

   task automatic test_flush();
      do_reset();
      drive(enc_r(OP_SUB, 4, 3, 5), 1'b1, 1'b1, 5'd5, 1'b1);
      n_checks++;
      if ({stall, bubble} !== 2'b01) begin n_errors++; $display("FAIL flush_haz got=%b exp=01", {stall, bubble}); end
      tick();
      n_checks++;
      if (stall_cnt !== 16'd0) begin n_errors++; $display("FAIL flush_cnt got=%0d exp=0", stall_cnt); end
      drive(enc_r(OP_SUB, 4, 3, 5), 1'b1, 1'b1, 5'd5, 1'b0);
      n_checks++;
      if ({stall, bubble} !== 2'b11) begin n_errors++; $display("FAIL flush_then_run got=%b exp=11", {stall, bubble}); end
      tick();
      drive(enc_r(OP_SUB, 4, 3, 5), 1'b1, 1'b1, 5'd5, 1'b1);
      n_checks++;
      if ({stall, bubble} !== 2'b01) begin n_errors++; $display("FAIL stall_flush got=%b exp=01", {stall, bubble}); end
      tick();
   endtask

   task automatic test_saturation();
      logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(enc_d(OP_LDUR, 2, 6, 0), 1'b1, 1'b1, 5'd6, 1'b0);
         tick();
         drive(32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
         tick();
         n_checks++;
         if (stall_cnt2 !== exp_c[k]) begin
            n_errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", k, stall_cnt2, exp_c[k]);
         end
      end
   endtask

   task automatic test_random();
      bit          m_stalled = 1'b0;
      int          m_cnt = 0, m_cnt2 = 0;
      logic [31:0] i;
      logic        v, mr, fl, haz, ex_st, ex_bb, ex_is, ex_ui;
      logic [4:0]  rd;
      int          kind;
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 63) == 0) begin
            reset = 1'b1;
            #1;
            n_checks++;
            if ({imm_sel, use_imm, stall, bubble, stall_cnt} !== {4'b0001, 16'd0}) begin
               n_errors++; $display("FAIL rnd_reset c=%0d got=%b cnt=%0d", c, {imm_sel, use_imm, stall, bubble}, stall_cnt);
            end
            m_stalled = 1'b0; m_cnt = 0; m_cnt2 = 0;
            tick();
            reset = 1'b0;
            #1;
         end
         kind = $urandom_range(0, 7);
         case (kind)
            0: i = enc_d(OP_LDUR, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
            1: i = enc_d(OP_STUR, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
            2: i = enc_i(OP_ADDI, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
            3: i = enc_i(OP_SUBI, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
            4: i = enc_r(($urandom_range(0, 1) != 0) ? OP_AND : OP_ADD, $urandom_range(0, 7),
                         $urandom_range(0, 7), $urandom_range(0, 7));
            5: i = enc_cb($urandom_range(0, 7), $urandom);
            6: i = {6'b000101, 26'($urandom)};
            default: i = $urandom;
         endcase
         v  = ($urandom_range(0, 7) != 0);
         mr = ($urandom_range(0, 2) != 0);
         rd = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
         fl = ($urandom_range(0, 9) == 0);
         drive(i, v, mr, rd, fl);
         haz   = v && mr && (rd != 5'd31) && (src_mask(i)[rd] == 1'b1);
         ex_is = v && ((i[31:21] == OP_LDUR) || (i[31:21] == OP_STUR));
         ex_ui = ex_is || (v && ((i[31:22] == OP_ADDI) || (i[31:22] == OP_SUBI)));
         ex_st = !m_stalled && haz && !fl;
         ex_bb = fl || (!m_stalled && haz);
         n_checks++;
         if ({imm_sel, use_imm, stall, bubble} !== {ex_is, ex_ui, ex_st, ex_bb}) begin
            n_errors++; $display("FAIL rnd_ctrl c=%0d i=%h got=%b exp=%b", c, i,
                                 {imm_sel, use_imm, stall, bubble}, {ex_is, ex_ui, ex_st, ex_bb});
         end
         tick();
         if (ex_st) begin
            m_cnt  = (m_cnt  < 65535) ? m_cnt + 1 : m_cnt;
            m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
         end
         m_stalled = ex_st;
         n_checks++;
         if (stall_cnt !== 16'(m_cnt) || stall_cnt2 !== 2'(m_cnt2)) begin
            n_errors++; $display("FAIL rnd_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, stall_cnt, stall_cnt2, m_cnt, m_cnt2);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      instr = '0; instr_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = '0; flush = 1'b0;
      #3;
      test_reset();
      test_decode();
      test_load_use();
      test_stur();
      test_flush();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
